// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Latches the decode control word, PC, instruction and register operands
// into EX. It also detects load-use hazards and inserts one bubble while
// IF/ID is held. Flush has the highest priority, then pipe_stall, then a
// hazard bubble.
// Optional build macro: IDEX_PERF_CNT_EN adds the bubble_cnt and flush_cnt
// performance counters.
module idex_pipe_reg #(
    parameter int CTRL_W = 20,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [31:0]       id_instr,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic              pipe_stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       ex_instr,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [4:0]        ex_rd,
    output logic              hazard_stall
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    // Control word field positions, counted from the LSB (load_regfile is bit 0).
    localparam int DCACHE_READ_BIT = 8;

    // RV32I opcodes that read a source register.
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    typedef enum logic {
        NORM = 1'b0,
        BUB  = 1'b1
    } state_e;

    logic              ex_valid_q, ex_valid_d;
    logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [31:0]       ex_instr_q, ex_instr_d;
    logic [XLEN-1:0]   ex_pc_q, ex_pc_d;
    logic [XLEN-1:0]   ex_rs1_q, ex_rs1_d;
    logic [XLEN-1:0]   ex_rs2_q, ex_rs2_d;
    state_e            state_q, state_d;

    logic              rs1_used;
    logic              rs2_used;
    logic              hazard;
    logic              hazard_bubble;
    logic [4:0]        ex_rd_w;

    assign ex_rd_w = ex_instr_q[11:7];

    // Decode which source registers the ID instruction actually reads.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and infers a latch.
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (id_instr[6:0])
            OP_JALR, OP_LOAD, OP_IMM: rs1_used = 1'b1;
            OP_BR, OP_STORE, OP_REG: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            default: ;
        endcase
    end

    // Load in EX whose nonzero rd feeds a source of the valid ID instruction.
    assign hazard = id_valid && ex_valid_q && ex_ctrl_q[DCACHE_READ_BIT] &&
                    (ex_rd_w != 5'd0) &&
                    ((rs1_used && (id_instr[19:15] == ex_rd_w)) ||
                     (rs2_used && (id_instr[24:20] == ex_rd_w)));

    // A hazard only turns into a bubble on an edge that neither flushes nor stalls.
    assign hazard_stall  = hazard && !flush && !pipe_stall;
    assign hazard_bubble = hazard_stall;

    // Next EX contents in priority order: flush, stall, hazard bubble, capture.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_instr_d = ex_instr_q;
        ex_pc_d    = ex_pc_q;
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;
        if (flush || hazard_bubble) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            ex_instr_d = '0;
            ex_pc_d    = '0;
            ex_rs1_d   = '0;
            ex_rs2_d   = '0;
        end else if (!pipe_stall) begin
            ex_valid_d = id_valid;
            ex_ctrl_d  = id_valid ? id_ctrl : '0;
            ex_instr_d = id_instr;
            ex_pc_d    = id_pc;
            ex_rs1_d   = id_rs1_data;
            ex_rs2_d   = id_rs2_data;
        end
    end

    // EX stage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            ex_instr_q <= '0;
            ex_pc_q    <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_instr_q <= ex_instr_d;
            ex_pc_q    <= ex_pc_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
        end
    end

    // Bubble tracker next state: enters BUB on a hazard bubble and leaves on the next free edge.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = NORM;
        end else if (!pipe_stall) begin
            state_d = hazard_bubble ? BUB : NORM;
        end
    end

    // Bubble tracker state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= NORM;
        end else begin
            state_q <= state_d;
        end
    end

    // A second hazard right after a bubble means the one-bubble guarantee broke.
    hazard_after_bubble_a : assert property (
        @(posedge clk) disable iff (!rst) !((state_q == BUB) && hazard)
    );

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Counters wrap naturally at 2^32.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (hazard_bubble) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
        if (flush && (ex_valid_q || id_valid)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`else
    // Performance counters are not built in this configuration.
`endif

    assign ex_valid    = ex_valid_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign ex_instr    = ex_instr_q;
    assign ex_pc       = ex_pc_q;
    assign ex_rs1_data = ex_rs1_q;
    assign ex_rs2_data = ex_rs2_q;
    assign ex_rd       = ex_rd_w;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Scoreboard bench for idex_pipe_reg: the driver applies one directed vector
// per cycle and queues the hand-computed outputs expected at the following
// negedge. A monitor pops and compares them there.
module tb_idex_pipe_reg;

    localparam int CTRL_W = 20;
    localparam int XLEN   = 32;

    // Control words: dcache_read is bit 8, dcache_write is bit 7, and load_regfile is bit 0.
    localparam logic [19:0] CTRL_LW  = 20'h00107;
    localparam logic [19:0] CTRL_ADD = 20'h40001;
    localparam logic [19:0] CTRL_ST  = 20'h00080;
    localparam logic [19:0] CTRL_LUI = 20'h00009;

    localparam logic [31:0] I_ADD_2_1_2 = 32'h00208133; // add x2,x1,x2
    localparam logic [31:0] I_LW_5      = 32'h0000A283; // lw  x5,0(x1)
    localparam logic [31:0] I_ADD_6_5_1 = 32'h00128333; // add x6,x5,x1
    localparam logic [31:0] I_LW_0      = 32'h0000A003; // lw  x0,0(x1)
    localparam logic [31:0] I_ADD_1_0_0 = 32'h000000B3; // add x1,x0,x0
    localparam logic [31:0] I_LUI_5     = 32'h000282B7; // lui x5,0x28 (rs1 field = 5)
    localparam logic [31:0] I_SW_5      = 32'h0050A023; // sw  x5,0(x1)

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [CTRL_W-1:0] id_ctrl;
    logic [31:0]       id_instr;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic              pipe_stall;
    logic              flush;
    logic              ex_valid;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [31:0]       ex_instr;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;
    logic [4:0]        ex_rd;
    logic              hazard_stall;
`ifdef IDEX_PERF_CNT_EN
    logic [31:0]       bubble_cnt;
    logic [31:0]       flush_cnt;
`endif

    idex_pipe_reg #(.CTRL_W(CTRL_W), .XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_ctrl      (id_ctrl),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_rs1_data  (id_rs1_data),
        .id_rs2_data  (id_rs2_data),
        .pipe_stall   (pipe_stall),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_ctrl      (ex_ctrl),
        .ex_instr     (ex_instr),
        .ex_pc        (ex_pc),
        .ex_rs1_data  (ex_rs1_data),
        .ex_rs2_data  (ex_rs2_data),
        .ex_rd        (ex_rd),
        .hazard_stall (hazard_stall)
`ifdef IDEX_PERF_CNT_EN
        ,
        .bubble_cnt   (bubble_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        v;
        logic [19:0] ctrl;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        hz;
        logic        chk_perf;
        logic [31:0] bcnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [19:0] ctrl, input logic [31:0] instr,
                         input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic stall, input logic fl);
        id_valid    = v;
        id_ctrl     = ctrl;
        id_instr    = instr;
        id_pc       = pc;
        id_rs1_data = rs1;
        id_rs2_data = rs2;
        pipe_stall  = stall;
        flush       = fl;
    endtask

    task automatic push_exp(input string name, input logic v, input logic [19:0] ctrl,
                            input logic [31:0] instr, input logic [31:0] pc,
                            input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [4:0] rd, input logic hz);
        exp_t e;
        e.name = name; e.v = v; e.ctrl = ctrl; e.instr = instr; e.pc = pc;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.hz = hz;
        e.chk_perf = 1'b0; e.bcnt = '0; e.fcnt = '0;
        exp_q.push_back(e);
    endtask

    // Empty EX stage (after reset or a bubble).
    task automatic push_zero(input string name, input logic hz);
        push_exp(name, 1'b0, 20'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, hz);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the DUT against the oldest queued expectation on each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".ex_valid"},     {31'd0, ex_valid},     {31'd0, e.v});
                check({e.name, ".ex_ctrl"},      {12'd0, ex_ctrl},      {12'd0, e.ctrl});
                check({e.name, ".ex_instr"},     ex_instr,              e.instr);
                check({e.name, ".ex_pc"},        ex_pc,                 e.pc);
                check({e.name, ".ex_rs1_data"},  ex_rs1_data,           e.rs1);
                check({e.name, ".ex_rs2_data"},  ex_rs2_data,           e.rs2);
                check({e.name, ".ex_rd"},        {27'd0, ex_rd},        {27'd0, e.rd});
                check({e.name, ".hazard_stall"}, {31'd0, hazard_stall}, {31'd0, e.hz});
`ifdef IDEX_PERF_CNT_EN
                if (e.chk_perf) begin
                    check({e.name, ".bubble_cnt"}, bubble_cnt, e.bcnt);
                    check({e.name, ".flush_cnt"},  flush_cnt,  e.fcnt);
                end
`endif
            end
        end
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Driver: each step drives the ID inputs and queues what the monitor must see this cycle.
    initial begin
        rst = 1'b0;
        drive(1'b0, 20'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        push_zero("reset", 1'b0);
        tick();

        // Reset is released between edges, then a plain add is captured.
        rst = 1'b1;
        drive(1'b1, CTRL_ADD, I_ADD_2_1_2, 32'h60, 32'd5, 32'd7, 1'b0, 1'b0);
        push_zero("post_reset", 1'b0);
        tick();
        drive(1'b0, 20'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        push_exp("capture", 1'b1, CTRL_ADD, I_ADD_2_1_2, 32'h60, 32'd5, 32'd7, 5'd2, 1'b0);
        tick();

        // Load-use on rs1: lw x5 then add x6,x5,x1 gives one bubble.
        drive(1'b1, CTRL_LW, I_LW_5, 32'h64, 32'h100, 32'h0, 1'b0, 1'b0);
        push_zero("idle_capture", 1'b0);
        tick();
        drive(1'b1, CTRL_ADD, I_ADD_6_5_1, 32'h68, 32'h11, 32'h22, 1'b0, 1'b0);
        push_exp("load_use", 1'b1, CTRL_LW, I_LW_5, 32'h64, 32'h100, 32'h0, 5'd5, 1'b1);
        tick();
        push_zero("bubble", 1'b0);
        tick();

        // Held add passes; then lw x0 followed by an x0 reader.
        drive(1'b1, CTRL_LW, I_LW_0, 32'h6C, 32'h0, 32'h0, 1'b0, 1'b0);
        push_exp("after_bubble", 1'b1, CTRL_ADD, I_ADD_6_5_1, 32'h68, 32'h11, 32'h22, 5'd6, 1'b0);
        tick();
        drive(1'b1, CTRL_ADD, I_ADD_1_0_0, 32'h70, 32'h0, 32'h0, 1'b0, 1'b0);
        push_exp("x0_no_hazard", 1'b1, CTRL_LW, I_LW_0, 32'h6C, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();

        // lw x5 followed by lui x5, which reads no source register.
        drive(1'b1, CTRL_LW, I_LW_5, 32'h74, 32'h200, 32'h0, 1'b0, 1'b0);
        push_exp("add_x1", 1'b1, CTRL_ADD, I_ADD_1_0_0, 32'h70, 32'h0, 32'h0, 5'd1, 1'b0);
        tick();
        drive(1'b1, CTRL_LUI, I_LUI_5, 32'h78, 32'h0, 32'h0, 1'b0, 1'b0);
        push_exp("lui_no_hazard", 1'b1, CTRL_LW, I_LW_5, 32'h74, 32'h200, 32'h0, 5'd5, 1'b0);
        tick();

        // Store data (rs2) matching a load rd must stall.
        drive(1'b1, CTRL_LW, I_LW_5, 32'h7C, 32'h300, 32'h0, 1'b0, 1'b0);
        push_exp("lui_capture", 1'b1, CTRL_LUI, I_LUI_5, 32'h78, 32'h0, 32'h0, 5'd5, 1'b0);
        tick();
        drive(1'b1, CTRL_ST, I_SW_5, 32'h80, 32'h1, 32'h2, 1'b0, 1'b0);
        push_exp("store_rs2_hazard", 1'b1, CTRL_LW, I_LW_5, 32'h7C, 32'h300, 32'h0, 5'd5, 1'b1);
        tick();
        push_zero("store_bubble", 1'b0);
        tick();

        // Three stalled edges hold the store in EX.
        drive(1'b1, CTRL_ADD, I_ADD_2_1_2, 32'h84, 32'd5, 32'd7, 1'b1, 1'b0);
        push_exp("store_capture", 1'b1, CTRL_ST, I_SW_5, 32'h80, 32'h1, 32'h2, 5'd0, 1'b0);
        tick();
        push_exp("stall_hold1", 1'b1, CTRL_ST, I_SW_5, 32'h80, 32'h1, 32'h2, 5'd0, 1'b0);
        tick();
        push_exp("stall_hold2", 1'b1, CTRL_ST, I_SW_5, 32'h80, 32'h1, 32'h2, 5'd0, 1'b0);
        tick();
        pipe_stall = 1'b0;
        push_exp("stall_hold3", 1'b1, CTRL_ST, I_SW_5, 32'h80, 32'h1, 32'h2, 5'd0, 1'b0);
        tick();

        // A hazard under pipe_stall holds EX; flush then wins over both.
        drive(1'b1, CTRL_LW, I_LW_5, 32'h88, 32'h400, 32'h0, 1'b0, 1'b0);
        push_exp("stall_release", 1'b1, CTRL_ADD, I_ADD_2_1_2, 32'h84, 32'd5, 32'd7, 5'd2, 1'b0);
        tick();
        drive(1'b1, CTRL_ADD, I_ADD_6_5_1, 32'h8C, 32'h11, 32'h22, 1'b1, 1'b0);
        push_exp("stall_masks_hz", 1'b1, CTRL_LW, I_LW_5, 32'h88, 32'h400, 32'h0, 5'd5, 1'b0);
        tick();
        flush = 1'b1;
        push_exp("flush_prio", 1'b1, CTRL_LW, I_LW_5, 32'h88, 32'h400, 32'h0, 5'd5, 1'b0);
        tick();
        flush = 1'b0;
        push_zero("flush_bubble", 1'b0);
        tick();

        // Counter snapshot, then an asynchronous reset between edges.
        drive(1'b1, CTRL_ADD, I_ADD_2_1_2, 32'h90, 32'd5, 32'd7, 1'b0, 1'b0);
        push_zero("flush_stall_hold", 1'b0);
        exp_q[exp_q.size()-1].chk_perf = 1'b1;
        exp_q[exp_q.size()-1].bcnt     = 32'd2;
        exp_q[exp_q.size()-1].fcnt     = 32'd1;
        tick();
        rst = 1'b0;
        push_zero("async_reset", 1'b0);
        exp_q[exp_q.size()-1].chk_perf = 1'b1;
        tick();
        rst = 1'b1;
        drive(1'b0, 20'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        push_zero("reset_release", 1'b0);
        tick();

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
